square_motion_ctrl: RTL and testbench

Per-frame motion sequencer for the square-drawing pixel pipeline. Once per frame, on a one-cycle frame pulse from the display timing generator, it applies any pending configuration, advances the square position by the configured speed, and reflects the square off the screen edges. It then publishes the new top-left corner atomically to the pixel-colour logic. Configuration reaches it through a valid/ready handshake.

---
 rtl/square_motion_ctrl_pkg.sv | 19 +
 rtl/square_motion_ctrl_axis_bounce.sv | 53 +++++
 rtl/square_motion_ctrl.sv | 147 ++++++++++++++
 tb/tb_square_motion_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/square_motion_ctrl_pkg.sv
`default_nettype none
// ---- square_motion_ctrl_pkg: shared state encoding and geometry defaults (rev 1.0) ----
package square_motion_ctrl_pkg;

  localparam int DEF_CORDW = 10;
  localparam int DEF_H_RES = 640;
  localparam int DEF_V_RES = 480;
  localparam int DEF_Q_SIZE = 32;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    APPLY  = 3'd1,
    MOVE_X = 3'd2,
    MOVE_Y = 3'd3,
    DONE   = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/square_motion_ctrl_axis_bounce.sv
`default_nettype none
// ---- square_motion_ctrl_axis_bounce: combinational one-axis step with edge reflection (rev 1.0) ----
module square_motion_ctrl_axis_bounce
  import square_motion_ctrl_pkg::*;
#(
  parameter int CORDW   = DEF_CORDW,
  parameter int SPEED_W = 4
) (
  input  logic [CORDW-1:0]   pos,
  input  logic               dir,
  input  logic [SPEED_W-1:0] speed,
  input  logic [CORDW-1:0]   limit,
  output logic [CORDW-1:0]   pos_next,
  output logic               dir_next,
  output logic               bounce
);

  // One guard bit so pos+speed near the top of the range cannot wrap
  logic [CORDW:0] pos_w;
  logic [CORDW:0] spd_w;
  logic [CORDW:0] lim_w;
  logic [CORDW:0] sum_w;

  assign pos_w = {1'b0, pos};
  assign spd_w = {{(CORDW + 1 - SPEED_W){1'b0}}, speed};
  assign lim_w = {1'b0, limit};
  assign sum_w = pos_w + spd_w;

  always_comb begin
    pos_next = pos;
    dir_next = dir;
    bounce   = 1'b0;
    if (dir) begin
      if (sum_w >= lim_w) begin
        pos_next = limit;
        dir_next = 1'b0;
        bounce   = 1'b1;
      end else begin
        pos_next = sum_w[CORDW-1:0];
      end
    end else begin
      if (pos_w <= spd_w) begin
        pos_next = '0;
        dir_next = 1'b1;
        bounce   = 1'b1;
      end else begin
        pos_next = pos - spd_w[CORDW-1:0];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/square_motion_ctrl.sv
`default_nettype none
// ---- square_motion_ctrl: per-frame square motion sequencer with shadowed config (rev 1.0) ----
module square_motion_ctrl
  import square_motion_ctrl_pkg::*;
#(
  parameter int CORDW     = DEF_CORDW,
  parameter int H_RES     = DEF_H_RES,
  parameter int V_RES     = DEF_V_RES,
  parameter int Q_SIZE    = DEF_Q_SIZE,
  parameter int SPEED_W   = 4,
  parameter int SPEED_RST = 1
) (
  input  logic               clk_pix,
  input  logic               sim_rst_n,
  input  logic               frame,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [SPEED_W-1:0] cfg_speed,
  input  logic               cfg_pause,
  output logic [CORDW-1:0]   qx,
  output logic [CORDW-1:0]   qy,
  output logic               busy,
  output logic               upd,
  output logic               bounce_x,
  output logic               bounce_y,
  output logic               frame_miss
);

  localparam logic [CORDW-1:0] X_LIM = CORDW'(H_RES - Q_SIZE);
  localparam logic [CORDW-1:0] Y_LIM = CORDW'(V_RES - Q_SIZE);

  state_t state;
  state_t state_nxt;

  logic [CORDW-1:0]   wx, wy;
  logic               dx, dy;
  logic [SPEED_W-1:0] speed, sh_speed;
  logic               pause, sh_pause;
  logic               pending, pending_nxt;
  logic               flag_bx;
  logic               xfer;
  logic               moving;
  logic [CORDW-1:0]   nx, ny;
  logic               ndx, ndy, nbx, nby;

  assign xfer   = cfg_valid && cfg_ready;
  assign moving = !pause && (speed != '0);

  square_motion_ctrl_axis_bounce #(.CORDW(CORDW), .SPEED_W(SPEED_W)) u_axis_x (
    .pos(wx), .dir(dx), .speed(speed), .limit(X_LIM),
    .pos_next(nx), .dir_next(ndx), .bounce(nbx)
  );

  square_motion_ctrl_axis_bounce #(.CORDW(CORDW), .SPEED_W(SPEED_W)) u_axis_y (
    .pos(wy), .dir(dy), .speed(speed), .limit(Y_LIM),
    .pos_next(ny), .dir_next(ndy), .bounce(nby)
  );

  always_ff @(posedge clk_pix or negedge sim_rst_n) begin
    if (!sim_rst_n) state <= IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (frame) state_nxt = APPLY;
      APPLY:   state_nxt = MOVE_X;
      MOVE_X:  state_nxt = MOVE_Y;
      MOVE_Y:  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    pending_nxt = pending;
    if (state == APPLY && pending) pending_nxt = 1'b0;
    else if (xfer)                 pending_nxt = 1'b1;
  end

  // Y is stepped and both axes published on the edge into DONE, so qx/qy move together
  always_ff @(posedge clk_pix or negedge sim_rst_n) begin
    if (!sim_rst_n) begin
      wx         <= '0;
      wy         <= '0;
      dx         <= 1'b1;
      dy         <= 1'b1;
      speed      <= SPEED_W'(SPEED_RST);
      pause      <= 1'b0;
      sh_speed   <= '0;
      sh_pause   <= 1'b0;
      pending    <= 1'b0;
      cfg_ready  <= 1'b1;
      flag_bx    <= 1'b0;
      qx         <= '0;
      qy         <= '0;
      busy       <= 1'b0;
      upd        <= 1'b0;
      bounce_x   <= 1'b0;
      bounce_y   <= 1'b0;
      frame_miss <= 1'b0;
    end else begin
      busy      <= (state_nxt != IDLE);
      upd       <= 1'b0;
      bounce_x  <= 1'b0;
      bounce_y  <= 1'b0;
      pending   <= pending_nxt;
      cfg_ready <= !pending_nxt;
      if (frame && state != IDLE) frame_miss <= 1'b1;
      if (xfer) begin
        sh_speed <= cfg_speed;
        sh_pause <= cfg_pause;
      end
      case (state)
        APPLY: begin
          if (pending) begin
            speed <= sh_speed;
            pause <= sh_pause;
          end
        end
        MOVE_X: begin
          if (moving) begin
            wx      <= nx;
            dx      <= ndx;
            flag_bx <= nbx;
          end
        end
        MOVE_Y: begin
          if (moving) begin
            wy <= ny;
            dy <= ndy;
          end
          qx       <= wx;
          qy       <= moving ? ny : wy;
          upd      <= 1'b1;
          bounce_x <= flag_bx;
          bounce_y <= moving && nby;
          flag_bx  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_square_motion_ctrl.sv
`default_nettype none
// ---- tb_square_motion_ctrl: directed self-checking bench for square_motion_ctrl (rev 1.0) ----
module tb_square_motion_ctrl;

  logic       clk_pix = 1'b0;
  logic       sim_rst_n = 1'b0;
  logic       frame = 1'b0;
  logic       cfg_valid = 1'b0;
  logic       cfg_pause = 1'b0;
  logic [3:0] cfg_speed = 4'd0;
  logic       cfg_ready;
  logic [9:0] qx, qy;
  logic       busy, upd, bounce_x, bounce_y, frame_miss;

  int checks = 0;
  int errors = 0;

  always #5 clk_pix = ~clk_pix;

  square_motion_ctrl dut (
    .clk_pix   (clk_pix),
    .sim_rst_n (sim_rst_n),
    .frame     (frame),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_speed (cfg_speed),
    .cfg_pause (cfg_pause),
    .qx        (qx),
    .qy        (qy),
    .busy      (busy),
    .upd       (upd),
    .bounce_x  (bounce_x),
    .bounce_y  (bounce_y),
    .frame_miss(frame_miss)
  );

  task automatic run_frame(input logic [9:0] ex, input logic [9:0] ey,
                           input logic ebx, input logic eby, input string tag);
    int n;
    int busy_cnt;
    logic [19:0] start_q;
    logic early;
    start_q = {qx, qy};
    early = 1'b0;
    @(negedge clk_pix); frame = 1'b1;
    @(negedge clk_pix); frame = 1'b0;
    n = 1;
    busy_cnt = busy ? 1 : 0;
    while (!upd && n < 8) begin
      if ({qx, qy} !== start_q) early = 1'b1;
      @(negedge clk_pix);
      n++;
      if (busy) busy_cnt++;
    end
    checks++;
    if (n !== 4) begin errors++; $display("FAIL %s latency: got %0d cycles, want 4", tag, n); end
    checks++;
    if (qx !== ex || qy !== ey) begin
      errors++; $display("FAIL %s position: got (%0d,%0d), want (%0d,%0d)", tag, qx, qy, ex, ey);
    end
    checks++;
    if (bounce_x !== ebx || bounce_y !== eby) begin
      errors++; $display("FAIL %s bounce: got x=%b y=%b, want x=%b y=%b", tag, bounce_x, bounce_y, ebx, eby);
    end
    checks++;
    if (early !== 1'b0) begin errors++; $display("FAIL %s qx/qy changed before upd: got 1, want 0", tag); end
    @(negedge clk_pix);
    checks++;
    if (busy !== 1'b0 || upd !== 1'b0 || bounce_x !== 1'b0 || bounce_y !== 1'b0) begin
      errors++; $display("FAIL %s tail: got busy=%b upd=%b bx=%b by=%b, want all 0", tag, busy, upd, bounce_x, bounce_y);
    end
    checks++;
    if (busy_cnt !== 4) begin errors++; $display("FAIL %s busy length: got %0d, want 4", tag, busy_cnt); end
  endtask

  task automatic set_cfg(input logic [3:0] s, input logic p);
    @(negedge clk_pix);
    checks++;
    if (cfg_ready !== 1'b1) begin errors++; $display("FAIL cfg_ready before offer: got %b, want 1", cfg_ready); end
    cfg_valid = 1'b1; cfg_speed = s; cfg_pause = p;
    @(negedge clk_pix);
    cfg_valid = 1'b0;
  endtask

  task automatic test_reset;
    sim_rst_n = 1'b0;
    repeat (2) @(negedge clk_pix);
    checks++;
    if (qx !== 10'd0 || qy !== 10'd0 || busy !== 1'b0 || upd !== 1'b0 || bounce_x !== 1'b0 ||
        bounce_y !== 1'b0 || frame_miss !== 1'b0 || cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset: got qx=%0d qy=%0d busy=%b upd=%b bx=%b by=%b miss=%b rdy=%b, want 0s with rdy=1",
               qx, qy, busy, upd, bounce_x, bounce_y, frame_miss, cfg_ready);
    end
    sim_rst_n = 1'b1;
  endtask

  task automatic test_basic_motion;
    for (int k = 1; k <= 3; k++) run_frame(10'(k), 10'(k), 1'b0, 1'b0, "basic");
  endtask

  task automatic test_cfg_handshake;
    @(negedge clk_pix);
    cfg_valid = 1'b1; cfg_speed = 4'd7; cfg_pause = 1'b0;
    @(negedge clk_pix);
    checks++;
    if (cfg_ready !== 1'b0) begin errors++; $display("FAIL cfg accept: got ready=%b, want 0", cfg_ready); end
    cfg_speed = 4'd2;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_pix);
      checks++;
      if (cfg_ready !== 1'b0) begin errors++; $display("FAIL cfg holdoff: got ready=%b, want 0", cfg_ready); end
    end
    cfg_valid = 1'b0;
    run_frame(10'd10, 10'd10, 1'b0, 1'b0, "cfg_speed7");
    checks++;
    if (cfg_ready !== 1'b1) begin errors++; $display("FAIL cfg release: got ready=%b, want 1", cfg_ready); end
  endtask

  task automatic test_bounce_x;
    int y;
    set_cfg(4'd15, 1'b0);
    for (int k = 1; k <= 39; k++) begin
      y = (k <= 29) ? 10 + 15 * k : 448 - 15 * (k - 30);
      run_frame(10'(10 + 15 * k), 10'(y), 1'b0, (k == 30), "sweep15");
    end
    set_cfg(4'd10, 1'b0);
    run_frame(10'd605, 10'd303, 1'b0, 1'b0, "to605");
    set_cfg(4'd4, 1'b0);
    run_frame(10'd608, 10'd299, 1'b1, 1'b0, "bounce_right");
    run_frame(10'd604, 10'd295, 1'b0, 1'b0, "after_right");
  endtask

  task automatic test_bounce_y;
    for (int k = 1; k <= 73; k++)
      run_frame(10'(604 - 4 * k), 10'(295 - 4 * k), 1'b0, 1'b0, "sweep4");
    set_cfg(4'd5, 1'b0);
    run_frame(10'd307, 10'd0, 1'b0, 1'b1, "bounce_top");
    set_cfg(4'd0, 1'b0);
    run_frame(10'd307, 10'd0, 1'b0, 1'b0, "speed0");
  endtask

  task automatic test_pause;
    set_cfg(4'd3, 1'b1);
    for (int k = 0; k < 5; k++) run_frame(10'd307, 10'd0, 1'b0, 1'b0, "paused");
  endtask

  task automatic test_back_to_back;
    set_cfg(4'd2, 1'b0);
    @(negedge clk_pix); frame = 1'b1;
    @(negedge clk_pix); frame = 1'b0;
    checks++;
    if (frame_miss !== 1'b0) begin errors++; $display("FAIL miss early: got %b, want 0", frame_miss); end
    @(negedge clk_pix); frame = 1'b1;
    @(negedge clk_pix); frame = 1'b0;
    repeat (6) @(negedge clk_pix);
    checks++;
    if (frame_miss !== 1'b1 || busy !== 1'b0 || qx !== 10'd305 || qy !== 10'd2) begin
      errors++;
      $display("FAIL miss: got miss=%b busy=%b q=(%0d,%0d), want miss=1 busy=0 q=(305,2)", frame_miss, busy, qx, qy);
    end
    run_frame(10'd303, 10'd4, 1'b0, 1'b0, "after_miss");
    checks++;
    if (frame_miss !== 1'b1) begin errors++; $display("FAIL miss sticky: got %b, want 1", frame_miss); end
  endtask

  task automatic test_reset_mid;
    @(negedge clk_pix); frame = 1'b1;
    @(negedge clk_pix); frame = 1'b0;
    cfg_valid = 1'b1; cfg_speed = 4'd9; cfg_pause = 1'b0;
    @(negedge clk_pix); cfg_valid = 1'b0;
    @(negedge clk_pix);
    sim_rst_n = 1'b0;
    #1;
    checks++;
    if (qx !== 10'd0 || qy !== 10'd0 || busy !== 1'b0 || upd !== 1'b0 || bounce_x !== 1'b0 ||
        bounce_y !== 1'b0 || frame_miss !== 1'b0 || cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid: got qx=%0d qy=%0d busy=%b upd=%b bx=%b by=%b miss=%b rdy=%b, want 0s with rdy=1",
               qx, qy, busy, upd, bounce_x, bounce_y, frame_miss, cfg_ready);
    end
    @(negedge clk_pix); sim_rst_n = 1'b1;
    run_frame(10'd1, 10'd1, 1'b0, 1'b0, "post_reset");
  endtask

  initial begin
    test_reset();
    test_basic_motion();
    test_cfg_handshake();
    test_bounce_x();
    test_bounce_y();
    test_pause();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
